// File: rtl/traffic_pkg.sv
// -----------------------------------------------------------------------------
// traffic_pkg
// Definitions shared by the vehicle queue sensor and the smart_traffic_light
// controller that consumes its outputs.
//   sensor_state_t    : debounce FSM states for the loop detector
//   RED/YELLOW/GREEN  : bit indices into the controller's lights vector
//   DEFAULT_QW        : default queue_count width
//   DEFAULT_QUEUE_MAX : default queue_count saturation value
// -----------------------------------------------------------------------------
package traffic_pkg;

  typedef enum logic [1:0] {
    ABSENT   = 2'd0,
    RISE_CHK = 2'd1,
    PRESENT  = 2'd2,
    FALL_CHK = 2'd3
  } sensor_state_t;

  localparam int RED    = 2;
  localparam int YELLOW = 1;
  localparam int GREEN  = 0;

  localparam int DEFAULT_QW        = 4;
  localparam int DEFAULT_QUEUE_MAX = 15;

endpackage

// File: rtl/vehicle_queue_sensor_if.sv
// -----------------------------------------------------------------------------
// vehicle_queue_sensor_if
// Groups the sensor's functional signals.
//   loop_raw        : raw loop-detector level (asynchronous to clk)
//   green_active    : approach currently shows green
//   car_detected    : demand = debounced presence OR non-empty queue
//   queue_count     : vehicles waiting (QW bits, saturating)
//   arrival_pulse   : one-cycle pulse per accepted arrival
//   departure_pulse : one-cycle pulse per departure
//   overflow        : sticky, arrival seen while the queue was full
// Modports: master drives the inputs (environment), slave is the sensor.
// -----------------------------------------------------------------------------
interface vehicle_queue_sensor_if
  import traffic_pkg::*;
#(
  parameter int QW = DEFAULT_QW
);

  logic          loop_raw;
  logic          green_active;
  logic          car_detected;
  logic [QW-1:0] queue_count;
  logic          arrival_pulse;
  logic          departure_pulse;
  logic          overflow;

  modport master (
    output loop_raw,
    output green_active,
    input  car_detected,
    input  queue_count,
    input  arrival_pulse,
    input  departure_pulse,
    input  overflow
  );

  modport slave (
    input  loop_raw,
    input  green_active,
    output car_detected,
    output queue_count,
    output arrival_pulse,
    output departure_pulse,
    output overflow
  );

endinterface

// File: rtl/vehicle_queue_sensor_loop_debounce.sv
// -----------------------------------------------------------------------------
// loop_debounce
// Two-flop synchroniser followed by a debounce FSM on the loop detector.
//   clk      : system clock, rising edge
//   rst      : asynchronous, active-low reset
//   loop_raw : raw loop level, asynchronous to clk
//   present  : presence as it will be after the coming edge (next-state view)
//   arrival  : high for the edge on which an arrival is accepted
// Both outputs are combinational decisions for the coming edge so the parent
// can register them in step with the queue counter.
// -----------------------------------------------------------------------------
module loop_debounce
  import traffic_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic loop_raw,
  output logic present,
  output logic arrival
);

  localparam int            CW   = $clog2(DEBOUNCE_CYCLES + 1);
  // cnt holds the number of stable samples already seen, so the sample being
  // evaluated now is the DEBOUNCE_CYCLES-th when cnt equals DEBOUNCE_CYCLES-1.
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          s1;
  logic          s2;
  sensor_state_t state;
  sensor_state_t state_n;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_n;

  // Synchroniser flops plus FSM state and debounce counter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1    <= 1'b0;
      s2    <= 1'b0;
      state <= ABSENT;
      cnt   <= '0;
    end else begin
      s1    <= loop_raw;
      s2    <= s1;
      state <= state_n;
      cnt   <= cnt_n;
    end
  end

  // Next-state and event decode; only the synchronised s2 is ever looked at.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    arrival = 1'b0;
    case (state)
      ABSENT: begin
        if (s2) begin
          state_n = RISE_CHK;
          cnt_n   = CW'(1);
        end
      end
      RISE_CHK: begin
        if (!s2) begin
          state_n = ABSENT;
          cnt_n   = '0;
        end else if (cnt == LAST) begin
          state_n = PRESENT;
          cnt_n   = '0;
          arrival = 1'b1;
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end
      PRESENT: begin
        if (!s2) begin
          state_n = FALL_CHK;
          cnt_n   = CW'(1);
        end
      end
      FALL_CHK: begin
        // Loop recovered before the gap was confirmed: same vehicle, no arrival.
        if (s2) begin
          state_n = PRESENT;
          cnt_n   = '0;
        end else if (cnt == LAST) begin
          state_n = ABSENT;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end
      default: begin
        state_n = ABSENT;
        cnt_n   = '0;
      end
    endcase
    present = (state_n == PRESENT) || (state_n == FALL_CHK);
  end

endmodule

// File: rtl/vehicle_queue_sensor.sv
// -----------------------------------------------------------------------------
// vehicle_queue_sensor
// Front end for smart_traffic_light: debounces the inductive loop, counts the
// queue of waiting vehicles and raises the demand signal.
//   clk : system clock, rising edge
//   rst : asynchronous, active-low reset
//   bus : vehicle_queue_sensor_if.slave
//         in  loop_raw, green_active
//         out car_detected, queue_count, arrival_pulse, departure_pulse,
//             overflow
// All outputs are registered.
// -----------------------------------------------------------------------------
module vehicle_queue_sensor
  import traffic_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int DEPART_CYCLES   = 3,
  parameter int QW              = DEFAULT_QW,
  parameter int QUEUE_MAX       = DEFAULT_QUEUE_MAX
) (
  input  logic                  clk,
  input  logic                  rst,
  vehicle_queue_sensor_if.slave bus
);

  localparam int            TW         = $clog2(DEPART_CYCLES + 1);
  localparam logic [TW-1:0] TIMER_LAST = TW'(DEPART_CYCLES - 1);
  localparam logic [QW-1:0] QMAX       = QW'(QUEUE_MAX);

  logic          present;
  logic          arrival;
  logic          departure;
  logic          overflow_set;
  logic [TW-1:0] timer;
  logic [TW-1:0] timer_n;
  logic [QW-1:0] queue_count;
  logic [QW-1:0] queue_n;
  logic          car_detected;
  logic          arrival_pulse;
  logic          departure_pulse;
  logic          overflow;

  loop_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_debounce (
    .clk      (clk),
    .rst      (rst),
    .loop_raw (bus.loop_raw),
    .present  (present),
    .arrival  (arrival)
  );

  // Departure timer: the edge that would bring it to DEPART_CYCLES is the
  // departure itself, so the first vehicle leaves DEPART_CYCLES edges after
  // green is seen with a non-empty queue. Gating on the registered count means
  // a departure is never issued from an empty queue.
  always_comb begin
    timer_n   = timer;
    departure = 1'b0;
    if (!bus.green_active || (queue_count == '0)) begin
      timer_n = '0;
    end else if (timer == TIMER_LAST) begin
      timer_n   = '0;
      departure = 1'b1;
    end else begin
      timer_n = timer + TW'(1);
    end
  end

  // Queue update; a simultaneous arrival and departure cancel out, even when
  // full, so overflow is only flagged for a lone arrival at QUEUE_MAX.
  always_comb begin
    queue_n      = queue_count;
    overflow_set = 1'b0;
    if (arrival && !departure) begin
      if (queue_count == QMAX) begin
        overflow_set = 1'b1;
      end else begin
        queue_n = queue_count + QW'(1);
      end
    end else if (!arrival && departure) begin
      queue_n = queue_count - QW'(1);
    end
  end

  // Output and state registers; car_detected is built from next-cycle values
  // so it moves on the same edge as queue_count and the pulses.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      timer           <= '0;
      queue_count     <= '0;
      car_detected    <= 1'b0;
      arrival_pulse   <= 1'b0;
      departure_pulse <= 1'b0;
      overflow        <= 1'b0;
    end else begin
      timer           <= timer_n;
      queue_count     <= queue_n;
      car_detected    <= present || (queue_n != '0);
      arrival_pulse   <= arrival;
      departure_pulse <= departure;
      overflow        <= overflow || overflow_set;
    end
  end

  assign bus.queue_count     = queue_count;
  assign bus.car_detected    = car_detected;
  assign bus.arrival_pulse   = arrival_pulse;
  assign bus.departure_pulse = departure_pulse;
  assign bus.overflow        = overflow;

endmodule

// File: tb/tb_vehicle_queue_sensor.sv
// -----------------------------------------------------------------------------
// tb_vehicle_queue_sensor
// Directed bench for vehicle_queue_sensor. Stimulus pushes the expected
// arrival/departure events (with the edge they must appear on) into a queue;
// a monitor pops and compares whenever the DUT shows a pulse.
// -----------------------------------------------------------------------------
module tb_vehicle_queue_sensor;

  localparam int QW = 4;

  typedef struct {
    logic arr;
    logic dep;
    int   q;
    logic car;
    logic ovf;
    int   at_edge;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  int   edge_count  = 0;
  int   check_count = 0;
  int   error_count = 0;
  exp_t exp_q[$];

  vehicle_queue_sensor_if #(.QW(QW)) bus ();

  vehicle_queue_sensor #(
    .DEBOUNCE_CYCLES (4),
    .DEPART_CYCLES   (3),
    .QW              (QW),
    .QUEUE_MAX       (15)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Free-running clock, rising edges at 5, 15, 25, ...
  always #5 clk = ~clk;

  // Rising-edge counter used to pin down event latency.
  always @(posedge clk) edge_count <= edge_count + 1;

  task automatic checkOutput(input string name, input int actual, input int expected);
    check_count++;
    if (actual != expected) begin
      error_count++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  // Called on a falling edge; the event must show after edge edge_count+delay.
  task automatic expectEvent(input logic arr, input logic dep, input int q,
                             input logic car, input logic ovf, input int delay);
    exp_t e;
    e.arr     = arr;
    e.dep     = dep;
    e.q       = q;
    e.car     = car;
    e.ovf     = ovf;
    e.at_edge = edge_count + delay;
    exp_q.push_back(e);
  endtask

  task automatic applyStimulus(input logic loop_v, input logic green_v, input int cycles);
    bus.loop_raw     = loop_v;
    bus.green_active = green_v;
    repeat (cycles) @(negedge clk);
  endtask

  // One vehicle: loop high 8 cycles then low 8, green off. Arrival is
  // accepted on the 6th edge after the loop rises.
  task automatic vehiclePass(input int q, input logic ovf);
    expectEvent(1'b1, 1'b0, q, 1'b1, ovf, 6);
    applyStimulus(1'b1, 1'b0, 8);
    applyStimulus(1'b0, 1'b0, 8);
  endtask

  task automatic checkIdle(input string tag, input int q, input logic car, input logic ovf);
    checkOutput({tag, "_queue"}, int'(bus.queue_count), q);
    checkOutput({tag, "_car"}, int'(bus.car_detected), int'(car));
    checkOutput({tag, "_arrival"}, int'(bus.arrival_pulse), 0);
    checkOutput({tag, "_departure"}, int'(bus.departure_pulse), 0);
    checkOutput({tag, "_overflow"}, int'(bus.overflow), int'(ovf));
  endtask

  // Monitor: every pulse must match the oldest expected event.
  always @(negedge clk) begin
    exp_t e;
    if (rst === 1'b1 && (bus.arrival_pulse === 1'b1 || bus.departure_pulse === 1'b1)) begin
      if (exp_q.size() == 0) begin
        check_count++;
        error_count++;
        $display("[TB] FAIL unexpected_event: got arrival=%0b departure=%0b at edge %0d, expected none",
                 bus.arrival_pulse, bus.departure_pulse, edge_count);
      end else begin
        e = exp_q.pop_front();
        checkOutput("event_edge", edge_count, e.at_edge);
        checkOutput("event_arrival", int'(bus.arrival_pulse), int'(e.arr));
        checkOutput("event_departure", int'(bus.departure_pulse), int'(e.dep));
        checkOutput("event_queue", int'(bus.queue_count), e.q);
        checkOutput("event_car", int'(bus.car_detected), int'(e.car));
        checkOutput("event_overflow", int'(bus.overflow), int'(e.ovf));
      end
    end
  end

  initial begin
    // Reset with the loop already occupied.
    rst              = 1'b0;
    bus.loop_raw     = 1'b1;
    bus.green_active = 1'b0;
    #8;
    checkIdle("reset", 0, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    $display("[TB] reset released at edge %0d", edge_count);
    expectEvent(1'b1, 1'b0, 1, 1'b1, 1'b0, 6);
    applyStimulus(1'b1, 1'b0, 10);
    applyStimulus(1'b0, 1'b0, 10);
    checkIdle("after_first", 1, 1'b1, 1'b0);

    // Drain that vehicle with green, then idle green on an empty queue.
    expectEvent(1'b0, 1'b1, 0, 1'b0, 1'b0, 3);
    applyStimulus(1'b0, 1'b1, 10);

    // Short 3-cycle blip must be rejected.
    applyStimulus(1'b1, 1'b0, 3);
    applyStimulus(1'b0, 1'b0, 10);
    checkIdle("glitch", 0, 1'b0, 1'b0);

    // Four vehicles queue up, then green drains them one per 3 cycles.
    for (int i = 1; i <= 4; i++) vehiclePass(i, 1'b0);
    expectEvent(1'b0, 1'b1, 3, 1'b1, 1'b0, 3);
    expectEvent(1'b0, 1'b1, 2, 1'b1, 1'b0, 6);
    expectEvent(1'b0, 1'b1, 1, 1'b1, 1'b0, 9);
    expectEvent(1'b0, 1'b1, 0, 1'b0, 1'b0, 12);
    applyStimulus(1'b0, 1'b1, 24);
    checkIdle("drained", 0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 2);

    // Saturation: 17 arrivals, overflow from the 16th on.
    for (int i = 1; i <= 17; i++) vehiclePass((i > 15) ? 15 : i, (i >= 16) ? 1'b1 : 1'b0);
    applyStimulus(1'b0, 1'b0, 5);
    checkIdle("saturated", 15, 1'b1, 1'b1);

    // Overflow clears only on reset.
    rst = 1'b0;
    #1;
    checkIdle("reset_overflow", 0, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b1;

    // Arrival coinciding with a departure at queue_count=2.
    vehiclePass(1, 1'b0);
    vehiclePass(2, 1'b0);
    expectEvent(1'b1, 1'b1, 2, 1'b1, 1'b0, 6);
    applyStimulus(1'b1, 1'b0, 3);
    applyStimulus(1'b1, 1'b1, 3);
    applyStimulus(1'b1, 1'b0, 2);
    applyStimulus(1'b0, 1'b0, 8);
    checkIdle("coincide", 2, 1'b1, 1'b0);

    // Reset in the middle of RISE_CHK with five queued.
    for (int i = 3; i <= 5; i++) vehiclePass(i, 1'b0);
    applyStimulus(1'b1, 1'b0, 4);
    rst = 1'b0;
    #1;
    checkIdle("mid_reset", 0, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    expectEvent(1'b1, 1'b0, 1, 1'b1, 1'b0, 6);
    applyStimulus(1'b1, 1'b0, 10);
    applyStimulus(1'b0, 1'b0, 10);
    checkIdle("post_reset", 1, 1'b1, 1'b0);

    checkOutput("scoreboard_pending", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", check_count, error_count);
    $finish;
  end

endmodule
